// File: rtl/multi_timer.sv
// Multi-channel memory-mapped timer. Each channel has a prescaler, a tick
// counter, free-running/one-shot modes and a sticky pending flag; pending
// flags gated by their enables are OR-ed into one registered interrupt.
module multi_timer #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic             hit;
    logic [1:0]       reg_sel;
    logic [N_CH-1:0]  ch_sel;
    logic [N_CH-1:0]  wr_ch;
    logic [N_CH-1:0]  tick;

    logic [N_CH-1:0]  en_q, en_d;
    logic [N_CH-1:0]  oneshot_q, oneshot_d;
    logic [N_CH-1:0]  ie_q, ie_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0] period_q [N_CH];
    logic [CNT_W-1:0] period_d [N_CH];
    logic [CNT_W-1:0] count_q  [N_CH];
    logic [CNT_W-1:0] count_d  [N_CH];
    logic [CNT_W-1:0] presc_q  [N_CH];
    logic [CNT_W-1:0] presc_d  [N_CH];

    logic [31:0]      rdata;
    logic             irq_d;
    logic             unused_bits;

    // Byte-lane bits and write data above CNT_W carry no meaning here.
    assign unused_bits = ^{addr_i[1:0], data_i};

    assign hit     = (addr_i[31:8] == BASE_ADDR[31:8]) && (32'(addr_i[7:4]) < N_CH);
    assign reg_sel = addr_i[3:2];

    // Channel select, write strobes and tick detection per channel.
    always_comb begin
        ch_sel = '0;
        wr_ch  = '0;
        tick   = '0;
        for (int c = 0; c < N_CH; c++) begin
            ch_sel[c] = hit && (addr_i[7:4] == 4'(c));
            wr_ch[c]  = we_i && ch_sel[c];
            // A PERIOD write restarts the prescaler and swallows a coincident tick.
            tick[c]   = en_q[c] && !(presc_q[c] < period_q[c]) &&
                        !(wr_ch[c] && (reg_sel == REG_PERIOD));
        end
    end

    // Next-state for every channel: status clear, counting, then bus writes win.
    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        ie_d      = ie_q;
        pend_d    = pend_q;
        for (int c = 0; c < N_CH; c++) begin
            period_d[c] = period_q[c];
            count_d[c]  = count_q[c];
            presc_d[c]  = presc_q[c];

            if (wr_ch[c] && (reg_sel == REG_STATUS) && data_i[0]) begin
                pend_d[c] = 1'b0;
            end

            if (en_q[c] && (presc_q[c] < period_q[c])) begin
                presc_d[c] = presc_q[c] + CNT_W'(1);
            end

            if (tick[c]) begin
                presc_d[c] = '0;
                count_d[c] = count_q[c] + CNT_W'(1);
                pend_d[c]  = 1'b1;
                if (oneshot_q[c]) begin
                    en_d[c] = 1'b0;
                end
            end

            if (wr_ch[c]) begin
                unique case (reg_sel)
                    REG_CTRL: begin
                        en_d[c]      = data_i[0];
                        oneshot_d[c] = data_i[1];
                        ie_d[c]      = data_i[2];
                    end
                    REG_PERIOD: begin
                        period_d[c] = data_i[CNT_W-1:0];
                        presc_d[c]  = '0;
                    end
                    REG_COUNT: begin
                        count_d[c] = data_i[CNT_W-1:0];
                    end
                    REG_STATUS: begin
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Read mux for the currently addressed register; misses read as zero.
    always_comb begin
        rdata = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_sel[c]) begin
                unique case (reg_sel)
                    REG_CTRL:   rdata[2:0] = {ie_q[c], oneshot_q[c], en_q[c]};
                    REG_PERIOD: rdata[CNT_W-1:0] = period_q[c];
                    REG_COUNT:  rdata[CNT_W-1:0] = count_q[c];
                    REG_STATUS: rdata[0] = pend_q[c];
                    default:    rdata = '0;
                endcase
            end
        end
    end

    // Combined interrupt request before registering.
    always_comb begin
        irq_d = |(pend_q & ie_q);
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q      <= '0;
            oneshot_q <= '0;
            ie_q      <= '0;
            pend_q    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                period_q[c] <= '0;
                count_q[c]  <= '0;
                presc_q[c]  <= '0;
            end
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            ie_q      <= ie_d;
            pend_q    <= pend_d;
            for (int c = 0; c < N_CH; c++) begin
                period_q[c] <= period_d[c];
                count_q[c]  <= count_d[c];
                presc_q[c]  <= presc_d[c];
            end
        end
    end

    // Registered read data and interrupt outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
            irq_o  <= 1'b0;
        end else begin
            data_o <= rdata;
            irq_o  <= irq_d;
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: a default 32-bit build plus an 8-bit build
// for counter wrap. Inputs change on the falling edge, outputs are read there.
module tb_multi_timer;

    localparam logic [31:0] BASE = 32'hFFFF_F200;
    localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] dout;
    logic        irq;

    logic        we8;
    logic [31:0] addr8;
    logic [31:0] data8;
    logic [31:0] dout8;
    logic        irq8;

    int checks;
    int failures;

    multi_timer u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .we_i   (we),
        .addr_i (addr),
        .data_i (data),
        .data_o (dout),
        .irq_o  (irq)
    );

    multi_timer #(
        .N_CH  (4),
        .CNT_W (8)
    ) u_dut8 (
        .clk_i  (clk),
        .rst_i  (rst),
        .we_i   (we8),
        .addr_i (addr8),
        .data_i (data8),
        .data_o (dout8),
        .irq_o  (irq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end on a falling edge; each write uses one rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        data = d;
        @(negedge clk);
        we = 1'b0;
        addr = IDLE_ADDR;
        data = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        @(negedge clk);
        d = dout;
        addr = IDLE_ADDR;
    endtask

    task automatic wr8(input logic [31:0] a, input logic [31:0] d);
        we8 = 1'b1;
        addr8 = a;
        data8 = d;
        @(negedge clk);
        we8 = 1'b0;
        addr8 = IDLE_ADDR;
        data8 = '0;
    endtask

    task automatic rd8(input logic [31:0] a, output logic [31:0] d);
        addr8 = a;
        @(negedge clk);
        d = dout8;
        addr8 = IDLE_ADDR;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) begin
                rd(BASE + 32'(ch * 16 + r * 4), v);
                checks++;
                if (v !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_reg ch%0d r%0d: got %h expected 0", ch, r, v);
                end
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        rd(BASE + 32'h100, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL reset_miss_read: got %h expected 0", v);
        end
    endtask

    task automatic test_free_run;
        logic [31:0] v;
        wr(BASE + 32'h04, 32'd3);
        wr(BASE + 32'h00, 32'h1);
        idle(39);
        wr(BASE + 32'h00, 32'h0);
        rd(BASE + 32'h08, v);
        checks++;
        if (v !== 32'd10) begin
            failures++;
            $display("FAIL free_run_count: got %0d expected 10", v);
        end
        rd(BASE + 32'h0C, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL free_run_pend: got %h expected 1", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL free_run_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_miss;
        logic [31:0] v;
        wr(32'hFFFF_F308, 32'h77);
        wr(BASE + 32'h48, 32'h77);
        rd(BASE + 32'h08, v);
        checks++;
        if (v !== 32'd10) begin
            failures++;
            $display("FAIL miss_write_ignored: got %0d expected 10", v);
        end
        rd(BASE + 32'h108, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL miss_read_upper: got %h expected 0", v);
        end
        rd(BASE + 32'h48, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL miss_read_channel: got %h expected 0", v);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        wr(BASE + 32'h14, 32'd5);
        wr(BASE + 32'h10, 32'h7);
        idle(6);
        // Tick has just landed; the registered interrupt follows one cycle later.
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq_latency: got %b expected 0", irq);
        end
        idle(1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_irq_set: got %b expected 1", irq);
        end
        idle(20);
        rd(BASE + 32'h18, v);
        checks++;
        if (v !== 32'd1) begin
            failures++;
            $display("FAIL oneshot_count: got %0d expected 1", v);
        end
        rd(BASE + 32'h10, v);
        checks++;
        if (v !== 32'h6) begin
            failures++;
            $display("FAIL oneshot_ctrl: got %h expected 6", v);
        end
        rd(BASE + 32'h1C, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL oneshot_pend: got %h expected 1", v);
        end
        wr(BASE + 32'h1C, 32'h1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_irq_hold: got %b expected 1", irq);
        end
        idle(1);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq_clear: got %b expected 0", irq);
        end
        rd(BASE + 32'h1C, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL oneshot_pend_clear: got %h expected 0", v);
        end
    endtask

    task automatic test_wrap8;
        logic [31:0] v;
        wr8(BASE + 32'h04, 32'hFFFF_FF12);
        rd8(BASE + 32'h04, v);
        checks++;
        if (v !== 32'h12) begin
            failures++;
            $display("FAIL wrap8_period_width: got %h expected 12", v);
        end
        wr8(BASE + 32'h08, 32'hFF);
        wr8(BASE + 32'h04, 32'h0);
        wr8(BASE + 32'h00, 32'h1);
        wr8(BASE + 32'h00, 32'h0);
        rd8(BASE + 32'h08, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL wrap8_count: got %h expected 0", v);
        end
        rd8(BASE + 32'h0C, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL wrap8_pend: got %h expected 1", v);
        end
        checks++;
        if (irq8 !== 1'b0) begin
            failures++;
            $display("FAIL wrap8_irq: got %b expected 0", irq8);
        end
    endtask

    task automatic test_collisions;
        logic [31:0] v;
        // ch2 with PERIOD=0 ticks on every enabled edge.
        wr(BASE + 32'h24, 32'h0);
        wr(BASE + 32'h20, 32'h1);
        wr(BASE + 32'h28, 32'h55);
        rd(BASE + 32'h28, v);
        checks++;
        if (v !== 32'h55) begin
            failures++;
            $display("FAIL coll_count_write: got %h expected 55", v);
        end
        wr(BASE + 32'h2C, 32'h1);
        rd(BASE + 32'h2C, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL coll_status_clear: got %h expected 1", v);
        end
        wr(BASE + 32'h20, 32'h0);
        rd(BASE + 32'h28, v);
        checks++;
        if (v !== 32'h59) begin
            failures++;
            $display("FAIL coll_count_run: got %h expected 59", v);
        end
        // PERIOD write on a would-be tick edge suppresses that tick.
        wr(BASE + 32'h20, 32'h1);
        wr(BASE + 32'h24, 32'd2);
        wr(BASE + 32'h20, 32'h0);
        rd(BASE + 32'h28, v);
        checks++;
        if (v !== 32'h59) begin
            failures++;
            $display("FAIL coll_period_write: got %h expected 59", v);
        end
        // CTRL write on a one-shot tick edge keeps the written EN.
        wr(BASE + 32'h20, 32'h3);
        idle(1);
        wr(BASE + 32'h20, 32'h3);
        rd(BASE + 32'h20, v);
        checks++;
        if (v !== 32'h3) begin
            failures++;
            $display("FAIL coll_ctrl_write: got %h expected 3", v);
        end
        wr(BASE + 32'h20, 32'h0);
        rd(BASE + 32'h28, v);
        checks++;
        if (v !== 32'h5A) begin
            failures++;
            $display("FAIL coll_ctrl_count: got %h expected 5a", v);
        end
    endtask

    task automatic test_isolation;
        logic [31:0] v;
        wr(BASE + 32'h04, 32'd1);
        wr(BASE + 32'h34, 32'd2);
        wr(BASE + 32'h08, 32'h0);
        wr(BASE + 32'h38, 32'h0);
        wr(BASE + 32'h00, 32'h1);
        wr(BASE + 32'h30, 32'h1);
        idle(58);
        wr(BASE + 32'h00, 32'h0);
        wr(BASE + 32'h30, 32'h0);
        rd(BASE + 32'h08, v);
        checks++;
        if (v !== 32'd30) begin
            failures++;
            $display("FAIL iso_ch0_count: got %0d expected 30", v);
        end
        rd(BASE + 32'h38, v);
        checks++;
        if (v !== 32'd20) begin
            failures++;
            $display("FAIL iso_ch3_count: got %0d expected 20", v);
        end
        rd(BASE + 32'h18, v);
        checks++;
        if (v !== 32'd1) begin
            failures++;
            $display("FAIL iso_ch1_count: got %0d expected 1", v);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        // ch0 PEND is still set, so enabling IE raises the interrupt.
        wr(BASE + 32'h00, 32'h5);
        rd(BASE + 32'h08, v);
        idle(2);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL mid_irq_before: got %b expected 1", irq);
        end
        addr = BASE + 32'h08;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL mid_irq_async: got %b expected 0", irq);
        end
        checks++;
        if (dout !== 32'h0) begin
            failures++;
            $display("FAIL mid_dout_async: got %h expected 0", dout);
        end
        @(negedge clk);
        rst = 1'b0;
        addr = IDLE_ADDR;
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) begin
                rd(BASE + 32'(ch * 16 + r * 4), v);
                checks++;
                if (v !== 32'h0) begin
                    failures++;
                    $display("FAIL mid_reset_reg ch%0d r%0d: got %h expected 0", ch, r, v);
                end
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_irq: got %b expected 0", irq);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        we    = 1'b0;
        addr  = IDLE_ADDR;
        data  = '0;
        we8   = 1'b0;
        addr8 = IDLE_ADDR;
        data8 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        test_reset;
        test_free_run;
        test_miss;
        test_oneshot;
        test_wrap8;
        test_collisions;
        test_isolation;
        test_reset_mid;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Memory-mapped, parametrised multi-channel timer peripheral on the CPU peripheral bus.
- Each channel has:
  - a prescaler that counts clock cycles up to a programmable period;
  - a tick counter that advances on each prescaler expiry;
  - free-running or one-shot mode;
  - a sticky pending flag with a per-channel interrupt enable.
- A single combined interrupt line goes to the core.

Parameters:
- N_CH, 4, number of timer channels (1..16).
- CNT_W, 32, width of the prescaler, period and tick counter (1..32).
- BASE_ADDR, 32'hFFFF_F200, block base address; bits [7:0] must be zero.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset
- we_i  input  1  bus write strobe, one cycle per write
- addr_i  input  32  bus byte address
- data_i  input  32  bus write data
- data_o  output  32  bus read data (registered)
- irq_o  output  1  combined interrupt request (registered)

Behaviour:
- Reset: rst_i is asynchronous and active-high; clock is clk_i. On reset, all channel registers, prescalers, data_o and irq_o are 0.
- Decode:
  - Hit when addr_i[31:8] == BASE_ADDR[31:8] and addr_i[7:4] < N_CH.
  - Channel = addr_i[7:4]; register = addr_i[3:2]; addr_i[1:0] ignored.
  - Writes that miss are ignored.
- Per-channel register map:
  - 0x0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IE. Read/write; other bits read 0.
  - 0x4 PERIOD: CNT_W bits, R/W. Writing it also clears that channel's prescaler.
  - 0x8 COUNT: CNT_W bits, R/W tick counter.
  - 0xC STATUS: bit0 PEND. Read returns PEND; writing 1 to bit0 clears it, writing 0 has no effect.
- Width rules: writes take data_i[CNT_W-1:0]; reads zero-extend to 32 bits.
- Read path: every cycle, data_o <= selected register for the current addr_i, or 0 on a miss. Read data is valid one cycle after the address. Reads have no side effects.
- Counting, per channel, each cycle with EN=1:
  - If prescaler < PERIOD: prescaler + 1.
  - Otherwise (tick):
    - prescaler <= 0;
    - COUNT <= COUNT + 1, wrapping from 2^CNT_W-1 to 0;
    - PEND <= 1;
    - if ONESHOT=1, EN <= 0.
  - PERIOD=0 ticks every enabled cycle. A tick occurs PERIOD+1 enabled cycles after the prescaler was cleared.
- EN=0: prescaler and COUNT hold their values. Re-enabling resumes from the held prescaler value.
- Simultaneous events in the same cycle, per channel:
  - COUNT write vs tick: the written value wins; PEND is still set and the prescaler is still cleared.
  - STATUS clear vs tick: set wins, so PEND=1.
  - CTRL write vs one-shot tick: the written CTRL value wins.
  - PERIOD write vs tick: the prescaler is cleared and no tick occurs that cycle.
- Channels are fully independent; a write affects only the addressed channel.
- irq_o <= OR over channels of (PEND & IE), registered, so one cycle after PEND/IE change.
- Reset mid-count: all state returns to 0 immediately, and irq_o deasserts asynchronously.

Test Plan:
- Reset, then read all 4×4 registers → all return 0; irq_o=0; a read of BASE+0x100 returns 0.
- Ch0: PERIOD=3, CTRL=0x1 → COUNT increments every 4 cycles; after 40 cycles COUNT=10; PEND=1; irq_o stays 0 (IE=0).
- Ch1 one-shot: PERIOD=5, CTRL=0x7 → exactly one tick; COUNT=1; CTRL reads 0x6; PEND=1; irq_o=1 one cycle after PEND. Write STATUS=1 → PEND=0 and irq_o falls the next cycle.
- CNT_W=8 build: COUNT=0xFF, PERIOD=0, EN=1 → the next cycle COUNT=0x00; read returns 0x00000000.
- Collisions on ch2 (PERIOD=0, EN): same-cycle COUNT write of 0x55 → COUNT=0x55 and PEND=1. Same-cycle STATUS clear → PEND remains 1.
- Channel isolation: run ch0 and ch3 with PERIOD 1 and 2 concurrently for 60 cycles → COUNT 30 and 20 respectively. Assert rst_i mid-run → all registers 0 immediately.
